// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches; resolves the oldest entry at execute,
// emits registered predictor feedback and misprediction recovery (flush, redirect PC, repaired GHR).
module branch_resolve_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int GHR_LEN    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push_valid,
  output logic                       o_push_ready,
  input  logic [ADDR_WIDTH-1:0]      i_push_pc,
  input  logic                       i_push_prediction,
  input  logic [ADDR_WIDTH-1:0]      i_push_recovery,
  input  logic [GHR_LEN-1:0]         i_push_ghr,
  input  logic                       i_res_valid,
  input  logic                       i_res_taken,
  input  logic                       i_ext_flush,
  output logic                       o_fb_valid,
  output logic [ADDR_WIDTH-1:0]      o_fb_pc,
  output logic                       o_fb_prediction,
  output logic                       o_fb_outcome,
  output logic                       o_mispredict,
  output logic [ADDR_WIDTH-1:0]      o_redirect_pc,
  output logic [GHR_LEN-1:0]         o_ghr_restore,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
  logic                  pred_mem[DEPTH];
  logic [ADDR_WIDTH-1:0] rec_mem [DEPTH];
  logic [GHR_LEN-1:0]    ghr_mem [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                  fb_valid_q, fb_pred_q, fb_out_q, mis_q, uflow_q;
  logic [ADDR_WIDTH-1:0] fb_pc_q, redir_q;
  logic [GHR_LEN-1:0]    ghr_q;

  logic                  res_acc, push_acc, mis, kill;
  logic                  head_pred;
  logic [ADDR_WIDTH-1:0] head_pc, head_rec;
  logic [GHR_LEN-1:0]    head_ghr;

  assign head_pc   = pc_mem[head_q];
  assign head_pred = pred_mem[head_q];
  assign head_rec  = rec_mem[head_q];
  assign head_ghr  = ghr_mem[head_q];

  // Ready comes from the registered count only; a same-cycle resolve does not free a slot early.
  assign o_push_ready = (count_q != CW'(DEPTH));
  assign res_acc      = i_res_valid & (count_q != '0);
  assign mis          = res_acc & (i_res_taken != head_pred);
  assign kill         = i_ext_flush | mis;
  assign push_acc     = i_push_valid & o_push_ready & ~kill;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) tail_d = tail_q + PW'(1);
      if (res_acc)  head_d = head_q + PW'(1);
      case ({push_acc, res_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      redir_q    <= '0;
      ghr_q      <= '0;
      uflow_q    <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fb_valid_q <= res_acc;
      // An external flush owns the redirect; the branch only reports feedback.
      mis_q      <= mis & ~i_ext_flush;
      if (mis && !i_ext_flush) begin
        redir_q <= head_rec;
        ghr_q   <= {head_ghr[GHR_LEN-2:0], i_res_taken};
      end
      if (i_res_valid && count_q == '0) uflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem[tail_q]   <= i_push_pc;
      pred_mem[tail_q] <= i_push_prediction;
      rec_mem[tail_q]  <= i_push_recovery;
      ghr_mem[tail_q]  <= i_push_ghr;
    end
    if (res_acc) begin
      fb_pc_q   <= head_pc;
      fb_pred_q <= head_pred;
      fb_out_q  <= i_res_taken;
    end
  end

  assign o_fb_valid      = fb_valid_q;
  assign o_fb_pc         = fb_pc_q;
  assign o_fb_prediction = fb_pred_q;
  assign o_fb_outcome    = fb_out_q;
  assign o_mispredict    = mis_q;
  assign o_redirect_pc   = redir_q;
  assign o_ghr_restore   = ghr_q;
  assign o_count         = count_q;
  assign o_underflow     = uflow_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Execute-side counterpart of the branch predictor request path. It produces the feedback stream (valid, pc, prediction, outcome) that the predictor consumes, and the misprediction recovery controls for the hazard controller.
- Holds an in-order queue of in-flight conditional branches. Each entry is pushed at decode with its prediction, recovery target and GHR snapshot.
- Branches resolve at execute in program order. Each resolution emits registered predictor feedback; a misprediction also produces a flush, a redirect PC and a repaired GHR.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
ADDR_WIDTH, 32, PC/target width
GHR_LEN, 8, global history length

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_push_valid  in  1  decode has a predicted conditional branch (not a jump)
o_push_ready  out  1  queue can accept a push this cycle
i_push_pc  in  ADDR_WIDTH  branch PC
i_push_prediction  in  1  1=TAKEN, 0=NOT_TAKEN
i_push_recovery  in  ADDR_WIDTH  PC to fetch if the prediction is wrong
i_push_ghr  in  GHR_LEN  GHR before this branch's speculative update
i_res_valid  in  1  execute resolves the oldest branch
i_res_taken  in  1  actual outcome
i_ext_flush  in  1  external squash (exception, jump redirect)
o_fb_valid  out  1  feedback to predictor
o_fb_pc  out  ADDR_WIDTH  feedback PC
o_fb_prediction  out  1  stored prediction
o_fb_outcome  out  1  actual outcome
o_mispredict  out  1  flush pulse to hazard controller
o_redirect_pc  out  ADDR_WIDTH  recovery fetch PC
o_ghr_restore  out  GHR_LEN  repaired GHR
o_count  out  $clog2(DEPTH)+1  occupancy
o_underflow  out  1  sticky error flag

Behaviour:
- Storage: circular buffer with head and tail pointers that wrap modulo DEPTH, plus a count. o_push_ready = (count != DEPTH), computed from the registered count only; no same-cycle bypass from a resolve.
- Push accepted when i_push_valid & o_push_ready & ~kill. Here kill = i_ext_flush | (resolve with mispredict). Accepted push writes the entry at tail and increments tail.
- A resolve is accepted when i_res_valid & count != 0. It pops the head entry and compares i_res_taken against the stored prediction.
- Feedback is registered, 1-cycle latency. In the cycle after an accepted resolve, o_fb_valid=1 with the head entry's pc and prediction, and o_fb_outcome=i_res_taken. o_fb_valid=0 otherwise.
- Misprediction is registered with the same cycle as feedback, and o_mispredict pulses 1 cycle:
  - o_redirect_pc = stored recovery target.
  - o_ghr_restore = {stored_ghr[GHR_LEN-2:0], i_res_taken}.
  - On the resolve edge the whole queue is cleared: head=tail=0, count=0. All younger entries are squashed, and a push in the same cycle is dropped.
- Correct prediction: pop only, no flush. o_redirect_pc and o_ghr_restore hold their last values.
- Simultaneous accepted push and correct resolve: count is unchanged, both pointers advance.
- i_ext_flush: clears the queue at the edge and overrides any push in the same cycle. A same-cycle resolve still emits feedback, but o_mispredict is suppressed.
- Resolve with count==0: ignored, no feedback. o_underflow is set and stays set until rst.
- Push when full: ignored; this is the producer's responsibility, since o_push_ready=0.
- Reset (rst=1 at the edge): count=0, head=tail=0, o_fb_valid=0, o_mispredict=0, o_redirect_pc=0, o_ghr_restore=0, o_underflow=0, o_push_ready=1 on the following cycle. Reset mid-operation discards all entries and any pending feedback.
- Resolve arithmetic: count+1 on push only, count-1 on resolve only, 0 on clear.

Test Plan:
- Push pc=0x100 pred=1 rec=0x108 ghr=0x5A, then resolve taken=1 -> next cycle o_fb_valid=1, pc=0x100, pred=1, outcome=1, o_mispredict=0, o_count=0.
- Push pc=0x200 pred=0 rec=0x300 ghr=0x0F, then resolve taken=1 -> next cycle o_mispredict=1, o_redirect_pc=0x300, o_ghr_restore=0x1F.
- Push 4 entries with DEPTH=4 -> o_push_ready=0. A fifth push is ignored. Resolve all 4 correctly -> feedback order matches push order, pointers wrap, o_count returns to 0.
- 3 entries queued; head mispredicts while a push is asserted -> queue empty afterwards (o_count=0), pushed entry dropped, exactly one o_mispredict pulse.
- i_ext_flush with 2 entries plus a same-cycle correct resolve -> one feedback, no mispredict, o_count=0.
- Resolve on an empty queue -> no o_fb_valid, o_underflow=1 held. Then assert rst mid-stream with entries queued -> all outputs return to reset values, o_underflow=0.
